// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: issues one FPU op at a time, times its latency by op
// class, and holds the result for writeback with a valid/ready handshake.
// Stalls decode on structural conflicts and on RAW hazards against the
// pending destination.
// Optional build macro FPSEQ_STATS_EN adds the StallCount/OpCount ports.
//
// state | meaning
// IDLE  | no op pending; decode may issue
// EXEC  | op in flight; counter counts down the remaining latency
// WB    | result valid; waiting for WBReady
module fpu_op_sequencer #(
  parameter int unsigned ADD_LAT = 2,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       DecValid,
  input  logic       IssueValid,
  input  logic [0:2] FPUOp,
  input  logic [0:4] IssueDest,
  input  logic       IssueFPDest,
  input  logic [0:4] SrcA,
  input  logic [0:4] SrcB,
  input  logic       SrcFP,
  input  logic       Flush,
  output logic       Stall,
  output logic       Start,
  output logic       Busy,
  output logic       WBValid,
  input  logic       WBReady,
  output logic [0:4] WBDest,
  output logic       WBFPDest
`ifdef FPSEQ_STATS_EN
  ,
  output logic [0:31] StallCount,
  output logic [0:31] OpCount
`endif
);

  if (ADD_LAT < 1 || ADD_LAT > 63 || MUL_LAT < 1 || MUL_LAT > 63 ||
      DIV_LAT < 1 || DIV_LAT > 63) begin : g_bad_lat
    $error("fpu_op_sequencer: latency parameters must be in 1..63");
  end

  localparam logic [5:0] ADD_L = 6'(ADD_LAT);
  localparam logic [5:0] MUL_L = 6'(MUL_LAT);
  localparam logic [5:0] DIV_L = 6'(DIV_LAT);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [0:4] dest_q, dest_d;
  logic       fpdest_q, fpdest_d;
  logic       start_q, start_d;
  logic       busy_q, wbvalid_q;
  logic       hs, strct, raw, accept;
  logic [5:0] lat;

  // Latency by op class; compare/convert/move (1xx) complete in one cycle.
  function automatic logic [5:0] lat_of(input logic [0:2] op);
    if (op[0])                 return 6'd1;
    else if (op[1:2] == 2'b11) return DIV_L;
    else if (op[1:2] == 2'b10) return MUL_L;
    else                       return ADD_L;
  endfunction

  // Hazard detection, stall and accept decision for the decode instruction.
  always_comb begin
    hs     = (state_q == WB) && WBReady;
    strct  = IssueValid && ((state_q == EXEC) || ((state_q == WB) && !WBReady));
    // GPR r0 is hardwired and never creates a hazard; FPR f0 is a real register.
    raw    = (state_q != IDLE) && !hs && (SrcFP == fpdest_q) &&
             ((SrcA == dest_q) || (SrcB == dest_q)) &&
             !(!fpdest_q && (dest_q == 5'd0));
    Stall  = DecValid && !Flush && (strct || raw);
    accept = IssueValid && DecValid && !Stall && !Flush &&
             ((state_q == IDLE) || hs);
    lat    = lat_of(FPUOp);
  end

  // Next-state logic; Flush wins over both the handshake and any accept.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dest_d   = dest_q;
    fpdest_d = fpdest_q;
    start_d  = 1'b0;
    if (Flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        EXEC: begin
          if (cnt_q == 6'd1) state_d = WB;
          else               cnt_d   = cnt_q - 6'd1;
        end
        WB: begin
          if (WBReady) state_d = IDLE;
        end
        default: ;
      endcase
      if (accept) begin
        dest_d   = IssueDest;
        fpdest_d = IssueFPDest;
        cnt_d    = lat - 6'd1;
        start_d  = 1'b1;
        state_d  = (lat == 6'd1) ? WB : EXEC;
      end
    end
  end

  // State and output registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dest_q    <= '0;
      fpdest_q  <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      wbvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dest_q    <= dest_d;
      fpdest_q  <= fpdest_d;
      start_q   <= start_d;
      busy_q    <= (state_d != IDLE);
      wbvalid_q <= (state_d == WB);
    end
  end

  assign Start    = start_q;
  assign Busy     = busy_q;
  assign WBValid  = wbvalid_q;
  assign WBDest   = dest_q;
  assign WBFPDest = fpdest_q;

`ifdef FPSEQ_STATS_EN
  logic [31:0] stall_cnt_q, op_cnt_q;

  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      op_cnt_q    <= '0;
    end else begin
      if (Stall)         stall_cnt_q <= stall_cnt_q + 32'd1;
      if (hs && !Flush)  op_cnt_q    <= op_cnt_q + 32'd1;
    end
  end

  assign StallCount = stall_cnt_q;
  assign OpCount    = op_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer: a per-cycle vector table for the
// short sequences plus hand-written multi-cycle corner cases.
module tb_fpu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset, DecValid, IssueValid, IssueFPDest, SrcFP, Flush, WBReady;
  logic [0:2] FPUOp;
  logic [0:4] IssueDest, SrcA, SrcB;
  logic       Stall, Start, Busy, WBValid, WBFPDest;
  logic [0:4] WBDest;
`ifdef FPSEQ_STATS_EN
  logic [0:31] StallCount, OpCount;
`endif

  int n_chk = 0;
  int n_fail = 0;

  fpu_op_sequencer dut (
    .clk(clk), .reset(reset), .DecValid(DecValid), .IssueValid(IssueValid),
    .FPUOp(FPUOp), .IssueDest(IssueDest), .IssueFPDest(IssueFPDest),
    .SrcA(SrcA), .SrcB(SrcB), .SrcFP(SrcFP), .Flush(Flush), .Stall(Stall),
    .Start(Start), .Busy(Busy), .WBValid(WBValid), .WBReady(WBReady),
    .WBDest(WBDest), .WBFPDest(WBFPDest)
`ifdef FPSEQ_STATS_EN
    , .StallCount(StallCount), .OpCount(OpCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dv, iv;
    logic [2:0] op;
    logic [4:0] dest;
    logic       fp;
    logic [4:0] sa, sb;
    logic       sfp, fl, rdy;
    logic       e_stall, e_start, e_busy, e_wbv;
    logic [4:0] e_dest;
    logic       e_fp;
  } vec_t;

  function automatic vec_t mk(int dv, int iv, int op, int dest, int fp,
                              int sa, int sb, int sfp, int fl, int rdy,
                              int es, int est, int eb, int ewv, int ed, int efp);
    vec_t v;
    v.dv = 1'(dv);  v.iv = 1'(iv);  v.op = 3'(op);  v.dest = 5'(dest);
    v.fp = 1'(fp);  v.sa = 5'(sa);  v.sb = 5'(sb);  v.sfp = 1'(sfp);
    v.fl = 1'(fl);  v.rdy = 1'(rdy);
    v.e_stall = 1'(es); v.e_start = 1'(est); v.e_busy = 1'(eb);
    v.e_wbv = 1'(ewv);  v.e_dest = 5'(ed);   v.e_fp = 1'(efp);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    DecValid = v.dv; IssueValid = v.iv; FPUOp = v.op; IssueDest = v.dest;
    IssueFPDest = v.fp; SrcA = v.sa; SrcB = v.sb; SrcFP = v.sfp;
    Flush = v.fl; WBReady = v.rdy;
  endtask

  task automatic idle_in();
    DecValid = 1'b0; IssueValid = 1'b0; FPUOp = 3'b000; IssueDest = 5'd0;
    IssueFPDest = 1'b0; SrcA = 5'd0; SrcB = 5'd0; SrcFP = 1'b0;
    Flush = 1'b0; WBReady = 1'b1;
  endtask

  task automatic issue(logic [2:0] op, logic [4:0] dest, logic fp, logic rdy);
    idle_in();
    DecValid = 1'b1; IssueValid = 1'b1; FPUOp = op;
    IssueDest = dest; IssueFPDest = fp; WBReady = rdy;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  vec_t tbl[30];
  int   stall_n, hs_cyc;
`ifdef FPSEQ_STATS_EN
  logic [31:0] ops_before;
`endif

  initial begin
    // dv iv op dest fp | sa sb sfp fl rdy | stall start busy wbv dest fp
    tbl[0]  = mk(1,1,0,3,1, 0,0,0,0,1, 0,0,0,0,0,0);
    tbl[1]  = mk(0,0,0,0,0, 0,0,0,0,1, 0,1,1,0,3,1);
    tbl[2]  = mk(0,0,0,0,0, 0,0,0,0,1, 0,0,1,1,3,1);
    tbl[3]  = mk(0,0,0,0,0, 0,0,0,0,1, 0,0,0,0,3,1);
    tbl[4]  = mk(1,1,4,7,0, 0,0,0,0,1, 0,0,0,0,3,1);
    tbl[5]  = mk(0,0,0,0,0, 0,0,0,0,1, 0,1,1,1,7,0);
    tbl[6]  = mk(0,0,0,0,0, 0,0,0,0,1, 0,0,0,0,7,0);
    tbl[7]  = mk(1,1,2,4,1, 0,0,0,0,1, 0,0,0,0,7,0);
    tbl[8]  = mk(1,0,0,0,0, 4,0,1,0,1, 1,1,1,0,4,1);
    tbl[9]  = mk(1,0,0,0,0, 4,0,1,0,1, 1,0,1,0,4,1);
    tbl[10] = mk(1,0,0,0,0, 4,0,1,0,1, 1,0,1,0,4,1);
    tbl[11] = mk(1,0,0,0,0, 4,0,1,0,1, 1,0,1,0,4,1);
    tbl[12] = mk(1,0,0,0,0, 4,0,1,0,1, 0,0,1,1,4,1);
    tbl[13] = mk(0,0,0,0,0, 0,0,0,0,1, 0,0,0,0,4,1);
    tbl[14] = mk(1,1,2,4,1, 0,0,0,0,1, 0,0,0,0,4,1);
    tbl[15] = mk(1,0,0,0,0, 4,0,0,0,1, 0,1,1,0,4,1);
    tbl[16] = mk(1,0,0,0,0, 4,0,0,0,1, 0,0,1,0,4,1);
    tbl[17] = mk(1,0,0,0,0, 0,4,1,0,1, 1,0,1,0,4,1);
    tbl[18] = mk(1,0,0,0,0, 4,0,0,0,1, 0,0,1,0,4,1);
    tbl[19] = mk(0,0,0,0,0, 0,0,0,0,1, 0,0,1,1,4,1);
    tbl[20] = mk(0,0,0,0,0, 0,0,0,0,1, 0,0,0,0,4,1);
    tbl[21] = mk(1,1,4,0,0, 0,0,0,0,0, 0,0,0,0,4,1);
    tbl[22] = mk(1,0,0,0,0, 0,0,0,0,0, 0,1,1,1,0,0);
    tbl[23] = mk(1,1,0,0,0, 0,0,0,0,0, 1,0,1,1,0,0);
    tbl[24] = mk(1,0,0,0,0, 0,0,0,0,1, 0,0,1,1,0,0);
    tbl[25] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0);
    tbl[26] = mk(1,1,4,0,1, 0,0,0,0,0, 0,0,0,0,0,0);
    tbl[27] = mk(1,0,0,0,0, 0,0,1,0,0, 1,1,1,1,0,1);
    tbl[28] = mk(1,0,0,0,0, 0,0,1,1,0, 0,0,1,1,0,1);
    tbl[29] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,1);

    idle_in();
    reset = 1'b1;
    step(); step();
    chk("rst_start", 32'(Start), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_wbvalid", 32'(WBValid), 0);
    chk("rst_wbdest", 32'(WBDest), 0);
    chk("rst_wbfp", 32'(WBFPDest), 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d_stall", i), 32'(Stall), 32'(tbl[i].e_stall));
      chk($sformatf("row%0d_start", i), 32'(Start), 32'(tbl[i].e_start));
      chk($sformatf("row%0d_busy", i), 32'(Busy), 32'(tbl[i].e_busy));
      chk($sformatf("row%0d_wbvalid", i), 32'(WBValid), 32'(tbl[i].e_wbv));
      chk($sformatf("row%0d_wbdest", i), 32'(WBDest), 32'(tbl[i].e_dest));
      chk($sformatf("row%0d_wbfp", i), 32'(WBFPDest), 32'(tbl[i].e_fp));
      step();
    end

    // DIV followed by an ADD held in decode: 18 stall cycles, then
    // back-to-back accept on the handshake cycle.
    idle_in();
    step();
    issue(3'b011, 5'd10, 1'b1, 1'b1);
    step();
    issue(3'b000, 5'd11, 1'b0, 1'b1);
    SrcA = 5'd1; SrcB = 5'd2; SrcFP = 1'b0;
    stall_n = 0;
    hs_cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      #1;
      if (!Stall) begin
        hs_cyc = i;
        break;
      end
      stall_n++;
      step();
    end
    chk("div_stall_cycles", 32'(stall_n), 18);
    chk("div_handshake_cycle", 32'(hs_cyc), 19);
    chk("div_wbvalid", 32'(WBValid), 1);
    chk("div_wbdest", 32'(WBDest), 10);
    step();
    idle_in();
    #1;
    chk("b2b_start", 32'(Start), 1);
    chk("b2b_busy", 32'(Busy), 1);
    chk("b2b_wbvalid", 32'(WBValid), 0);
    chk("b2b_wbdest", 32'(WBDest), 11);
    step();
    chk("b2b_wb_wbvalid", 32'(WBValid), 1);
    step();
    chk("b2b_idle_busy", 32'(Busy), 0);

    // WBReady held low for 7 cycles: WB output stays stable.
    issue(3'b000, 5'd5, 1'b0, 1'b0);
    step();
    idle_in(); WBReady = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("hold%0d_wbvalid", i), 32'(WBValid), 1);
      chk($sformatf("hold%0d_wbdest", i), 32'(WBDest), 5);
      if (i < 6) step();
    end
    WBReady = 1'b1;
    step();
    chk("hold_release_busy", 32'(Busy), 0);
    chk("hold_release_wbvalid", 32'(WBValid), 0);

    // Flush mid-EXEC of a DIV, with a competing issue in the flush cycle.
    issue(3'b011, 5'd9, 1'b1, 1'b1);
    step();
    idle_in();
    step(); step(); step(); step();
    issue(3'b000, 5'd12, 1'b0, 1'b1);
    Flush = 1'b1;
    #1;
    chk("flush_exec_stall", 32'(Stall), 0);
    step();
    idle_in();
    #1;
    chk("flush_exec_busy", 32'(Busy), 0);
    chk("flush_exec_wbvalid", 32'(WBValid), 0);
    chk("flush_exec_start", 32'(Start), 0);

    // Flush in a WB cycle with WBReady high discards the result.
    issue(3'b100, 5'd2, 1'b1, 1'b1);
    step();
    idle_in();
`ifdef FPSEQ_STATS_EN
    ops_before = OpCount;
`endif
    Flush = 1'b1;
    #1;
    chk("flush_wb_wbvalid_before", 32'(WBValid), 1);
    step();
    idle_in();
    #1;
    chk("flush_wb_busy", 32'(Busy), 0);
    chk("flush_wb_wbvalid", 32'(WBValid), 0);
`ifdef FPSEQ_STATS_EN
    chk("flush_wb_opcount", OpCount, ops_before);
`endif

    // Reset asserted while in EXEC.
    issue(3'b010, 5'd6, 1'b1, 1'b1);
    step();
    idle_in();
    step();
    chk("pre_rst_busy", 32'(Busy), 1);
    reset = 1'b1;
    step();
    chk("exec_rst_start", 32'(Start), 0);
    chk("exec_rst_busy", 32'(Busy), 0);
    chk("exec_rst_wbvalid", 32'(WBValid), 0);
    chk("exec_rst_wbdest", 32'(WBDest), 0);
    chk("exec_rst_wbfp", 32'(WBFPDest), 0);
    reset = 1'b0;
    step(); step();
    chk("post_rst_busy", 32'(Busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
Sequences multi-cycle FPU operations for the pipelined DLX core. It sits between decode/ID and the FPU/WB stage. It accepts one FPU instruction at a time, tracks its latency by op class, and holds the result for the writeback port with a valid/ready handshake. It also stalls decode on structural conflicts (FPU busy) and on RAW hazards against the pending destination register.

Parameters:
ADD_LAT, 2, cycles from accept to WBValid for add/sub (FPUOp 000/001); range 1..63
MUL_LAT, 5, cycles for multiply (FPUOp 010); range 1..63
DIV_LAT, 19, cycles for divide (FPUOp 011); range 1..63
(FPUOp 1xx, i.e. compare/convert/move, has a fixed latency of 1)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous reset, active-high
DecValid  in  1  decode holds a valid instruction (used for the RAW check)
IssueValid  in  1  decode instruction is an FPU op requesting issue; only meaningful with DecValid=1
FPUOp  in  [0:2]  FPU operation select from control
IssueDest  in  [0:4]  destination register of the issuing op
IssueFPDest  in  1  1 = destination is an FPR, 0 = destination is a GPR
SrcA, SrcB  in  [0:4]  source registers of the decode instruction
SrcFP  in  1  1 = sources are FPRs
Flush  in  1  squash the pending op (branch/jump redirect)
Stall  out  1  combinational; hold the IF/ID stages
Start  out  1  registered; one-cycle pulse telling the FPU to latch its operands
Busy  out  1  registered; high whenever state != IDLE
WBValid  out  1  registered; result available for writeback
WBReady  in  1  writeback port accepts the result
WBDest  out  [0:4]  registered; destination of the pending op
WBFPDest  out  1  registered; FPR/GPR select of the pending op

Behaviour:
- States: IDLE, EXEC, WB. Reset puts the FSM in IDLE and clears Start, Busy, WBValid, WBDest, WBFPDest and the counter. Reset overrides Flush and issue.
- Accept condition: IssueValid & DecValid & !Stall & !Flush, evaluated in IDLE or in WB on a handshake cycle.
- On accept:
  - Latch FPUOp class, IssueDest and IssueFPDest.
  - Load the counter with LAT-1. LAT is selected by FPUOp: 000/001=ADD_LAT, 010=MUL_LAT, 011=DIV_LAT, 1xx=1.
  - Next cycle: Start=1 for exactly one cycle.
- Next state after accept: EXEC if LAT>1; WB if LAT=1.
- EXEC: the counter decrements each cycle. When counter==1 the next state is WB. WBValid therefore first rises exactly LAT cycles after the accept edge.
- WB:
  - WBValid=1 is held, with WBDest/WBFPDest stable, until the cycle where WBValid & WBReady.
  - On that handshake: next state is IDLE, or EXEC/WB directly if an accept occurs in the same cycle (back-to-back; no bubble).
  - WBReady low: the FSM stays in WB indefinitely.
- Stall = DecValid & !Flush & (Struct | RAW):
  - Struct = IssueValid & (state==EXEC | (state==WB & !WBReady)).
  - RAW = state!=IDLE & !(state==WB & WBReady) & SrcFP==WBFPDest & (SrcA==WBDest | SrcB==WBDest) & !(WBFPDest==0 & WBDest==0). GPR r0 never hazards; FPR f0 does.
- Flush:
  - In any state: next state IDLE, WBValid/Busy drop the following cycle, and no accept occurs that cycle.
  - Flush has priority over a same-cycle WB handshake; the result is discarded.
  - Start already pulsed is not recalled; the FPU output is simply ignored.
- Counter: 6 bits. LAT outside 1..63 is illegal; the implementation flags it with a parameter check at elaboration.

Optional Feature:
FPSEQ_STATS_EN:
- Defined: adds output ports StallCount [0:31] and OpCount [0:31], both cleared by reset.
  - StallCount increments every cycle Stall=1.
  - OpCount increments on every completed WB handshake that is not flushed.
  - Both wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then ADD (FPUOp=000, IssueDest=3, FPDest=1) with default params and WBReady=1 -> Start at cycle 1; WBValid at cycle 2 with WBDest=3; Busy=0 at cycle 3.
- DIV (011) issued, then a second FPU op held in decode -> Stall=1 for 18 cycles; second op accepted on the handshake cycle (cycle 19); no idle cycle between ops.
- MUL to f4 pending, decode instruction with SrcFP=1 and SrcA=4 -> Stall=1 until the WB handshake. Same case with SrcFP=0 -> Stall=0. GPR dest r0 with SrcA=0 -> Stall=0.
- WBReady held 0 for 7 cycles after WBValid rises -> WBValid and WBDest stay stable for 7 cycles; handshake on cycle 8 returns to IDLE.
- Flush asserted mid-EXEC of DIV and again in a WB cycle with WBReady=1 -> IDLE next cycle, WBValid=0, no handshake counted (OpCount unchanged with FPSEQ_STATS_EN).
- FPUOp=100 (compare) -> Start and WBValid both occur on cycle 1 after accept. Reset asserted in EXEC -> all outputs 0 next cycle.
